data_mem_loader: RTL and testbench

//  Sits directly upstream of data_mem and owns its DataAddress/ReadMem/WriteMem/DataIn port.

---
 rtl/data_mem_loader_pkg.sv | 11 +
 rtl/data_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_data_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_loader_pkg.sv
// Shared types and default widths for the data_mem loader/dumper.
package data_mem_loader_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {IDLE, LOAD, DUMP, FINISH} ldr_state_t;

   typedef logic [DEF_ADDR_W:0] ldr_count_t;

endpackage

// File: rtl/data_mem_loader.sv
// Owns the data_mem port: core pass-through when idle, otherwise
// bulk LOAD from a valid/ready byte stream or DUMP onto one.
module data_mem_loader
   import data_mem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_read,
   input  logic              core_write,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic [ADDR_W-1:0] DataAddress,
   output logic              ReadMem,
   output logic              WriteMem,
   output logic [DATA_W-1:0] DataIn,
   input  logic [DATA_W-1:0] DataOut
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   ldr_state_t        r_state;
   ldr_state_t        w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [CNT_W-1:0]  r_remaining;
   logic [CNT_W-1:0]  w_remaining_nxt;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] w_out_data_nxt;
   logic              r_out_valid;
   logic              w_out_valid_nxt;

   logic              w_load_hs;
   logic              w_dump_slot;

   assign w_load_hs   = (r_state == LOAD) && in_valid;
   // Output register is free either because it is empty or being consumed.
   assign w_dump_slot = (r_state == DUMP) && (!r_out_valid || out_ready);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_remaining <= w_remaining_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_remaining_nxt = r_remaining;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_addr_nxt      = base_addr;
               w_remaining_nxt = length;
               if (length == '0) begin
                  w_state_nxt = FINISH;
               end else if (mode) begin
                  w_state_nxt = DUMP;
               end else begin
                  w_state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            if (w_load_hs) begin
               w_addr_nxt      = r_addr + ADDR_W'(1);
               w_remaining_nxt = r_remaining - CNT_W'(1);
               if (r_remaining == CNT_W'(1)) begin
                  w_state_nxt = FINISH;
               end
            end
         end
         DUMP: begin
            if (w_dump_slot) begin
               if (r_remaining != '0) begin
                  w_out_data_nxt  = DataOut;
                  w_out_valid_nxt = 1'b1;
                  w_addr_nxt      = r_addr + ADDR_W'(1);
                  w_remaining_nxt = r_remaining - CNT_W'(1);
               end else begin
                  // Last byte consumed (or nothing pending): close the stream.
                  w_out_valid_nxt = 1'b0;
                  w_state_nxt     = FINISH;
               end
            end
         end
         FINISH: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Memory-port mux: core owns the port only while idle.
   always_comb begin
      DataAddress = core_addr;
      ReadMem     = core_read;
      WriteMem    = core_write;
      DataIn      = core_wdata;

      case (r_state)
         IDLE: begin
         end
         LOAD: begin
            DataAddress = r_addr;
            ReadMem     = 1'b0;
            WriteMem    = w_load_hs;
            DataIn      = in_data;
         end
         DUMP: begin
            DataAddress = r_addr;
            ReadMem     = 1'b1;
            WriteMem    = 1'b0;
            DataIn      = '0;
         end
         default: begin
            DataAddress = r_addr;
            ReadMem     = 1'b0;
            WriteMem    = 1'b0;
            DataIn      = '0;
         end
      endcase
   end

   assign in_ready   = (r_state == LOAD);
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == FINISH);
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign core_rdata = DataOut;

   a_done_pulse: assert property (@(posedge CLK) disable iff (reset)
      done |=> !done);

   a_out_hold: assert property (@(posedge CLK) disable iff (reset)
      (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_data)));

   a_core_isolated: assert property (@(posedge CLK) disable iff (reset)
      (busy && WriteMem) |-> ((r_state == LOAD) && in_valid));

endmodule

// File: tb/tb_data_mem_loader.sv
// Randomized bench for data_mem_loader against an array-level memory model.
module tb_data_mem_loader;
   import data_mem_loader_pkg::*;

   localparam int unsigned AW    = DEF_ADDR_W;
   localparam int unsigned DW    = DEF_DATA_W;
   localparam int unsigned DEPTH = 1 << AW;

   logic          CLK = 1'b0;
   logic          reset;
   logic          start;
   logic          mode;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic [AW-1:0] core_addr;
   logic          core_read;
   logic          core_write;
   logic [DW-1:0] core_wdata;
   logic [DW-1:0] core_rdata;
   logic [AW-1:0] DataAddress;
   logic          ReadMem;
   logic          WriteMem;
   logic [DW-1:0] DataIn;
   logic [DW-1:0] DataOut;

   data_mem_loader dut (
      .CLK(CLK), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .length(length),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done),
      .core_addr(core_addr), .core_read(core_read), .core_write(core_write),
      .core_wdata(core_wdata), .core_rdata(core_rdata),
      .DataAddress(DataAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
      .DataIn(DataIn), .DataOut(DataOut)
   );

   always #5 CLK = ~CLK;

   // data_mem stand-in: synchronous write, asynchronous read
   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   int unsigned   wr_cnt;

   always @(posedge CLK) begin
      if (WriteMem) begin
         mem[DataAddress] <= DataIn;
         wr_cnt           <= wr_cnt + 1;
      end
   end
   assign DataOut = mem[DataAddress];

   int n_cmp = 0;
   int n_err = 0;
   logic [DW-1:0] stim_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      core_addr = '0; core_read = 1'b0; core_write = 1'b0; core_wdata = '0;
   endtask

   task automatic core_wr(input int a, input int d);
      core_addr = AW'(a); core_wdata = DW'(d); core_write = 1'b1;
      step();
      core_write = 1'b0;
      ref_mem[AW'(a)] = DW'(d);
   endtask

   task automatic core_rd_check(input int a);
      core_addr = AW'(a); core_read = 1'b1;
      #1;
      check("core_rdata", 32'(core_rdata), 32'(ref_mem[AW'(a)]));
      check("core_readmem", 32'(ReadMem), 32'd1);
      core_read = 1'b0;
   endtask

   // LOAD of stim_q[0..len-1]; optionally keeps start asserted to show it is ignored
   task automatic do_load(input int base, input int len, input bit rnd_valid, input bit poke_start);
      int idx = 0;
      int cyc = 0;
      int budget = len * 8 + 20;
      bit hs;
      mode = 1'b0; base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1;
      step();
      start = poke_start; mode = 1'b1; base_addr = AW'(base + 77); length = (AW+1)'(5);
      while (idx < len && cyc < budget) begin
         in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = stim_q[idx];
         #1;
         hs = in_valid && in_ready;
         step();
         if (hs) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      if (idx != len) check("load_timeout", 32'(idx), 32'(len));
      check("load_done", 32'(done), 32'd1);
      check("load_busy_fin", 32'(busy), 32'd1);
      step();
      start = 1'b0;
      check("load_done_drop", 32'(done), 32'd0);
      check("load_idle", 32'(busy), 32'd0);
      for (int i = 0; i < len; i++) ref_mem[AW'(base + i)] = stim_q[i];
   endtask

   // ready_mode: 0 = always ready, 1 = random, 2 = two-cycle stall before the third byte
   task automatic do_dump(input int base, input int len, input int ready_mode);
      int got = 0;
      int cyc = 0;
      int stalls = 0;
      int first = -1;
      int last = -1;
      int budget = len * 8 + 20;
      logic [DW-1:0] held;
      mode = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1;
      step();
      start = 1'b0;
      while (got < len && cyc < budget) begin
         if (ready_mode == 1)                          out_ready = 1'($urandom_range(0, 1));
         else if (ready_mode == 2 && got == 2 && stalls < 2) out_ready = 1'b0;
         else                                          out_ready = 1'b1;
         #1;
         if (out_valid && out_ready) begin
            check("dump_data", 32'(out_data), 32'(ref_mem[AW'(base + got)]));
            if (first < 0) first = cyc;
            last = cyc;
            got++;
            step();
         end else if (out_valid) begin
            stalls++;
            held = out_data;
            step();
            check("dump_hold", 32'({out_valid, out_data}), 32'({1'b1, held}));
         end else begin
            step();
         end
         cyc++;
      end
      out_ready = 1'b0;
      if (got != len) check("dump_timeout", 32'(got), 32'(len));
      if (ready_mode == 0 && len > 0) check("dump_burst", 32'(last - first), 32'(len - 1));
      check("dump_done", 32'(done), 32'd1);
      check("dump_valid_off", 32'(out_valid), 32'd0);
      step();
      check("dump_done_drop", 32'(done), 32'd0);
      check("dump_idle", 32'(busy), 32'd0);
   endtask

   task automatic compare_all_mem();
      int diffs = 0;
      for (int a = 0; a < int'(DEPTH); a++) if (mem[a] !== ref_mem[a]) diffs++;
      check("mem_all", 32'(diffs), 32'd0);
   endtask

   initial begin
      int op, base, len;
      int unsigned w0;
      logic [DW-1:0] v;

      idle_inputs();
      reset = 1'b1;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      step();

      for (int a = 0; a < int'(DEPTH); a++) core_wr(a, int'($urandom_range(0, 255)));
      for (int k = 0; k < 4; k++) core_rd_check(int'($urandom_range(0, 255)));

      // LOAD 0x0F len 3 with start held high throughout
      stim_q = '{8'd3, 8'd7, 8'd9};
      do_load(32'h0F, 3, 1'b0, 1'b1);
      check("mem_0f", 32'(mem[8'h0F]), 32'd3);
      check("mem_10", 32'(mem[8'h10]), 32'd7);
      check("mem_11", 32'(mem[8'h11]), 32'd9);

      do_dump(32'h0F, 3, 0);
      do_dump(32'h0E, 4, 2);

      // address wrap
      stim_q = '{8'd1, 8'd2, 8'd4};
      do_load(32'hFE, 3, 1'b0, 1'b0);
      check("mem_fe", 32'(mem[8'hFE]), 32'd1);
      check("mem_ff", 32'(mem[8'hFF]), 32'd2);
      check("mem_00", 32'(mem[8'h00]), 32'd4);
      do_dump(32'hFD, 5, 0);

      // zero length, with start still high during FINISH
      w0 = wr_cnt;
      stim_q.delete();
      do_load(32'h40, 0, 1'b0, 1'b1);
      check("len0_no_write", wr_cnt - w0, 32'd0);
      do_dump(32'h40, 0, 0);

      // reset in the middle of a LOAD, core write attempted while busy
      core_wr(32'h20, 32'hC3);
      mode = 1'b0; base_addr = 8'h30; length = 9'd4; start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b1; in_data = 8'hA5;
      step();
      in_valid = 1'b0;
      core_addr = 8'h20; core_wdata = 8'd7; core_write = 1'b1;
      #1;
      check("core_wr_blocked", 32'(WriteMem), 32'd0);
      step();
      core_write = 1'b0;
      in_valid = 1'b1; in_data = 8'h5A;
      #1;
      reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      step();
      check("abort_done_hold", 32'(done), 32'd0);
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      step();
      check("abort_idle", 32'(busy), 32'd0);
      ref_mem[8'h30] = 8'hA5;
      check("abort_mem30", 32'(mem[8'h30]), 32'hA5);
      check("abort_mem31", 32'(mem[8'h31]), 32'(ref_mem[8'h31]));
      check("abort_mem20", 32'(mem[8'h20]), 32'hC3);

      // whole memory, randomized handshakes
      stim_q.delete();
      for (int i = 0; i < int'(DEPTH); i++) begin
         v = DW'($urandom_range(0, 255));
         stim_q.push_back(v);
      end
      do_load(int'($urandom_range(0, 255)), int'(DEPTH), 1'b1, 1'b0);
      do_dump(int'($urandom_range(0, 255)), int'(DEPTH), 1);
      compare_all_mem();

      repeat (40) begin
         op   = int'($urandom_range(0, 3));
         base = int'($urandom_range(0, 255));
         len  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
         case (op)
            0: begin
               for (int k = 0; k < 3; k++) core_wr(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
               core_rd_check(base);
            end
            1: begin
               stim_q.delete();
               for (int i = 0; i < len; i++) begin
                  v = DW'($urandom_range(0, 255));
                  stim_q.push_back(v);
               end
               do_load(base, len, 1'b1, 1'($urandom_range(0, 1)));
            end
            default: do_dump(base, len, int'($urandom_range(0, 1)));
         endcase
      end
      compare_all_mem();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
